// File: rtl/key_event_unit.sv
// Multi-channel key front end: sync, debounce, press/release pulses, optional auto-repeat (KEY_AUTOREPEAT_EN).
// Press/release accepted DEBOUNCE_CYCLES+3 edges after the pin changes; no backpressure, pulses are fire-and-forget.
module key_event_unit #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] repeat_flag,
  output logic [N_KEYS-1:0] release_pulse,
  output logic              any_press,
  output logic [7:0]        press_total
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (N_KEYS < 1 || N_KEYS > 16 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("key_event_unit: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  state_t            state_q [N_KEYS];
  state_t            state_d [N_KEYS];
  logic [CNT_W-1:0]  cnt_q   [N_KEYS];
  logic [CNT_W-1:0]  cnt_d   [N_KEYS];
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] rflag_q, rflag_d;
  logic [7:0]        total_q, total_d;

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0]  rpt_q [N_KEYS];
  logic [RPT_W-1:0]  rpt_d [N_KEYS];
  // first_q: the next repeat uses the long initial delay
  logic [N_KEYS-1:0] first_q, first_d;
`endif

  always_comb begin
    press_d   = '0;
    release_d = '0;
    rflag_d   = '0;
    level_d   = '0;
`ifdef KEY_AUTOREPEAT_EN
    first_d   = first_q;
`endif
    for (int k = 0; k < N_KEYS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      case (state_q[k])
        IDLE: begin
          if (sync2_q[k]) begin
            state_d[k] = DEB_PRESS;
            cnt_d[k]   = '0;
          end
        end
        DEB_PRESS: begin
          if (!sync2_q[k]) begin
            state_d[k] = IDLE;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k] = HELD;
            press_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
        HELD: begin
          if (!sync2_q[k]) begin
            state_d[k] = DEB_RELEASE;
            cnt_d[k]   = '0;
          end
        end
        DEB_RELEASE: begin
          if (sync2_q[k]) begin
            state_d[k] = HELD;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k]   = IDLE;
            release_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
        default: state_d[k] = IDLE;
      endcase
      level_d[k] = (state_d[k] == HELD) || (state_d[k] == DEB_RELEASE);

`ifdef KEY_AUTOREPEAT_EN
      rpt_d[k] = rpt_q[k];
      if (state_q[k] == DEB_PRESS && state_d[k] == HELD) begin
        rpt_d[k]   = '0;
        first_d[k] = 1'b1;
      end else if (state_q[k] == HELD) begin
        // counts every HELD cycle, including the one that starts a release debounce
        if (rpt_q[k] == (first_q[k] ? DELAY_LAST : PERIOD_LAST)) begin
          rpt_d[k]   = '0;
          first_d[k] = 1'b0;
          press_d[k] = 1'b1;
          rflag_d[k] = 1'b1;
        end else begin
          rpt_d[k] = rpt_q[k] + RPT_W'(1);
        end
      end
      if (state_d[k] == IDLE) begin
        rpt_d[k]   = '0;
        first_d[k] = 1'b0;
      end
`endif
    end

    total_d = total_q;
    for (int k = 0; k < N_KEYS; k++) begin
      if (press_q[k] && !rflag_q[k]) total_d = total_d + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      rflag_q   <= '0;
      total_q   <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      sync1_q   <= ~key_n;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      rflag_q   <= rflag_d;
      total_q   <= total_d;
      for (int k = 0; k < N_KEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      first_q <= '0;
      for (int k = 0; k < N_KEYS; k++) rpt_q[k] <= '0;
    end else begin
      first_q <= first_d;
      for (int k = 0; k < N_KEYS; k++) rpt_q[k] <= rpt_d[k];
    end
  end
`endif

  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign repeat_flag   = rflag_q;
  assign release_pulse = release_q;
  assign any_press     = |press_q;
  assign press_total   = total_q;

endmodule
